// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, key-scheduler state encoding, forward S-box and GF(2^8) xtime.
package aes_pkg;

  localparam int AES_NR = 10;
  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    STREAM = 2'd2,
    ZERO   = 2'd3
  } state_t;

  // Row-major forward S-box; entry 0 occupies the top byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    // Byte b sits at bit offset 8*(255-b), and 255-b == ~b for an 8-bit value.
    sbox = SBOX_TABLE[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] r);
    xtime = {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_key_expand_step.sv
// One combinational AES-128 key-expansion step: next round key from the previous one and its rcon.
module aes_key_expand_step
  import aes_pkg::*;
#(
  parameter int KEY_W = 128
) (
  input  logic [KEY_W-1:0] rk_prev,
  input  logic [7:0]       rcon,
  output logic [KEY_W-1:0] rk_next
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, sub, t;
  logic [31:0] n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = rk_prev;
  assign rot = {w3[23:0], w3[31:24]};

  for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
    assign sub[8*gi +: 8] = sbox(rot[8*gi +: 8]);
  end

  assign t  = sub ^ {rcon, 24'h000000};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign rk_next = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_dec_key_sched.sv
// AES-128 decrypt round-key source: forward expansion into an 11-entry store, then streams rounds 10..0.
// Optional AES_DEC_KEY_ZEROIZE_EN: wipe the store for one cycle after each stream or flush.
module aes_dec_key_sched
  import aes_pkg::*;
#(
  parameter int NR     = AES_NR,
  parameter int KEY_W  = 128,
  parameter int RIDX_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [KEY_W-1:0]  key_in,
  input  logic              key_valid,
  output logic              key_ready,
  input  logic              replay,
  input  logic              flush,
  output logic [KEY_W-1:0]  rk_out,
  output logic [RIDX_W-1:0] rk_round,
  output logic              rk_last,
  output logic              rk_valid,
  input  logic              rk_ready,
  output logic              busy
);

  localparam logic [RIDX_W-1:0] LAST_IDX = RIDX_W'(NR);

  state_t              state;
  logic [RIDX_W-1:0]   cnt;
  logic [RIDX_W-1:0]   idx;
  logic [RIDX_W-1:0]   prev_idx;
  logic [7:0]          rcon;
  logic                sched_ok;
  logic [KEY_W-1:0]    store [0:NR];
  logic [KEY_W-1:0]    step_out;

  assign prev_idx = (cnt == '0) ? '0 : cnt - RIDX_W'(1);

  aes_key_expand_step #(
    .KEY_W (KEY_W)
  ) u_step (
    .rk_prev (store[prev_idx]),
    .rcon    (rcon),
    .rk_next (step_out)
  );

  assign rk_round = idx;
  assign rk_out   = rk_valid ? store[idx] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      rcon      <= '0;
      sched_ok  <= 1'b0;
      rk_valid  <= 1'b0;
      rk_last   <= 1'b0;
      busy      <= 1'b0;
      key_ready <= 1'b1;
      for (int i = 0; i <= NR; i++) store[i] <= '0;
    end else if (flush) begin
      // sched_ok is already low during EXPAND (cleared at key load), so an aborted expansion stays unusable.
      rk_valid <= 1'b0;
      rk_last  <= 1'b0;
      idx      <= '0;
      cnt      <= '0;
`ifdef AES_DEC_KEY_ZEROIZE_EN
      state     <= ZERO;
      busy      <= 1'b1;
      key_ready <= 1'b0;
`else
      state     <= IDLE;
      busy      <= 1'b0;
      key_ready <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (key_valid) begin
            store[0]  <= key_in;
            rcon      <= RCON_INIT;
            cnt       <= RIDX_W'(1);
            sched_ok  <= 1'b0;
            state     <= EXPAND;
            busy      <= 1'b1;
            key_ready <= 1'b0;
          end else if (replay && sched_ok) begin
            idx       <= LAST_IDX;
            rk_valid  <= 1'b1;
            rk_last   <= 1'b0;
            state     <= STREAM;
            busy      <= 1'b1;
            key_ready <= 1'b0;
          end
        end

        EXPAND: begin
          store[cnt] <= step_out;
          rcon       <= xtime(rcon);
          cnt        <= cnt + RIDX_W'(1);
          if (cnt == LAST_IDX) begin
            sched_ok <= 1'b1;
            idx      <= LAST_IDX;
            rk_valid <= 1'b1;
            rk_last  <= 1'b0;
            state    <= STREAM;
          end
        end

        STREAM: begin
          if (rk_ready) begin
            if (idx == '0) begin
              rk_valid <= 1'b0;
              rk_last  <= 1'b0;
`ifdef AES_DEC_KEY_ZEROIZE_EN
              state    <= ZERO;
`else
              state     <= IDLE;
              busy      <= 1'b0;
              key_ready <= 1'b1;
`endif
            end else begin
              idx     <= idx - RIDX_W'(1);
              rk_last <= (idx == RIDX_W'(1));
            end
          end
        end

`ifdef AES_DEC_KEY_ZEROIZE_EN
        ZERO: begin
          for (int i = 0; i <= NR; i++) store[i] <= '0;
          sched_ok  <= 1'b0;
          state     <= IDLE;
          busy      <= 1'b0;
          key_ready <= 1'b1;
        end
`endif

        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          key_ready <= 1'b1;
          rk_valid  <= 1'b0;
          rk_last   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_dec_key_sched.sv
// Directed bench for aes_dec_key_sched: scoreboard of expected round keys, immediate-assertion checks.
// Honours AES_DEC_KEY_ZEROIZE_EN the same way as the design.
module tb_aes_dec_key_sched;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic         replay;
  logic         flush;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic         rk_last;
  logic         rk_valid;
  logic         rk_ready;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [131:0] sb_q [$];
  logic [127:0] fips_rk [0:10];
  logic [127:0] seq_rk  [0:10];

  always #5 clk = ~clk;

  aes_dec_key_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_in    (key_in),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .replay    (replay),
    .flush     (flush),
    .rk_out    (rk_out),
    .rk_round  (rk_round),
    .rk_last   (rk_last),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_sched(input bit use_fips);
    for (int r = 10; r >= 0; r--) begin
      logic [3:0] rr;
      rr = 4'(r);
      sb_q.push_back({rr, use_fips ? fips_rk[r] : seq_rk[r]});
    end
  endtask

  // Called at a negedge while the key is visible; returns at the negedge after the accepting edge.
  task automatic load_key(input logic [127:0] k);
    key_in    = k;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  // Consume up to 'want' transfers; random_ready stalls the consumer. Entered and left at a negedge.
  task automatic drain(input int want, input bit random_ready, output int cycles);
    int           n;
    bit           prev_stall;
    logic [127:0] prev_out;
    logic [3:0]   prev_round;
    logic [131:0] e;
    n          = 0;
    cycles     = 0;
    prev_stall = 0;
    prev_out   = '0;
    prev_round = '0;
    while (n < want && cycles < 200) begin
      rk_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (prev_stall) begin
        check("stall_valid", {127'd0, rk_valid}, 128'd1);
        check("stall_out", rk_out, prev_out);
        check("stall_round", {124'd0, rk_round}, {124'd0, prev_round});
      end
      prev_stall = 0;
      if (rk_valid === 1'b1) begin
        if (rk_ready) begin
          if (sb_q.size() == 0) begin
            check("sb_underflow", 128'd1, 128'd0);
          end else begin
            e = sb_q.pop_front();
            check($sformatf("rk_round_%0d", e[131:128]), {124'd0, rk_round}, {124'd0, e[131:128]});
            check($sformatf("rk_out_r%0d", e[131:128]), rk_out, e[127:0]);
            check($sformatf("rk_last_r%0d", e[131:128]), {127'd0, rk_last},
                  {127'd0, (e[131:128] == 4'd0)});
          end
          n++;
        end else begin
          prev_stall = 1;
          prev_out   = rk_out;
          prev_round = rk_round;
        end
      end
      cycles++;
      @(negedge clk);
    end
    rk_ready = 1'b1;
    check("xfer_count", 128'(n), 128'(want));
  endtask

  // Watch rk_valid for a number of cycles; any high cycle is a failure.
  task automatic expect_quiet(input string tag, input int n_cyc);
    int highs;
    highs = 0;
    for (int c = 0; c < n_cyc; c++) begin
      if (rk_valid !== 1'b0) highs++;
      @(negedge clk);
    end
    check(tag, 128'(highs), 128'd0);
  endtask

  task automatic post_stream_checks(input string tag);
    check({tag, "_valid_drop"}, {127'd0, rk_valid}, 128'd0);
    check({tag, "_out_zero"}, rk_out, 128'd0);
`ifdef AES_DEC_KEY_ZEROIZE_EN
    check({tag, "_busy_zero_state"}, {127'd0, busy}, 128'd1);
    @(negedge clk);
`endif
    check({tag, "_busy_idle"}, {127'd0, busy}, 128'd0);
    check({tag, "_key_ready"}, {127'd0, key_ready}, 128'd1);
  endtask

  initial begin
    int cyc;

    fips_rk = '{
      128'h2b7e151628aed2a6abf7158809cf4f3c,
      128'ha0fafe1788542cb123a339392a6c7605,
      128'hf2c295f27a96b9435935807a7359f67f,
      128'h3d80477d4716fe3e1e237e446d7a883b,
      128'hef44a541a8525b7fb671253bdb0bad00,
      128'hd4d1c6f87c839d87caf2b8bc11f915bc,
      128'h6d88a37a110b3efddbf98641ca0093fd,
      128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
      128'head27321b58dbad2312bf5607f8d292f,
      128'hac7766f319fadc2128d12941575c006e,
      128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };
    seq_rk = '{
      128'h000102030405060708090a0b0c0d0e0f,
      128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
      128'hb692cf0b643dbdf1be9bc5006830b3fe,
      128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
      128'h47f7f7bc95353e03f96c32bcfd058dfd,
      128'h3caaa3e8a99f9deb50f3af57adf622aa,
      128'h5e390f7df7a69296a7553dc10aa31f6b,
      128'h14f9701ae35fe28c440adf4d4ea9c026,
      128'h47438735a41c65b9e016baf4aebf7ad2,
      128'h549932d1f08557681093ed9cbe2c974e,
      128'h13111d7fe3944a17f307a78b4d2b30c5
    };

    rst_n     = 1'b0;
    key_in    = '0;
    key_valid = 1'b0;
    replay    = 1'b0;
    flush     = 1'b0;
    rk_ready  = 1'b1;
    repeat (3) @(negedge clk);

    // Reset values while held in reset
    check("rst_rk_out", rk_out, 128'd0);
    check("rst_rk_round", {124'd0, rk_round}, 128'd0);
    check("rst_rk_valid", {127'd0, rk_valid}, 128'd0);
    check("rst_rk_last", {127'd0, rk_last}, 128'd0);
    check("rst_busy", {127'd0, busy}, 128'd0);
    check("rst_key_ready", {127'd0, key_ready}, 128'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Sequential key, back-to-back consumer, exact start latency
    push_sched(1'b0);
    load_key(128'h000102030405060708090a0b0c0d0e0f);
    check("exp_busy", {127'd0, busy}, 128'd1);
    check("exp_key_ready", {127'd0, key_ready}, 128'd0);
    repeat (9) @(negedge clk);
    check("lat_T10_valid", {127'd0, rk_valid}, 128'd0);
    @(negedge clk);
    check("lat_T11_valid", {127'd0, rk_valid}, 128'd1);
    drain(11, 1'b0, cyc);
    check("b2b_cycles", 128'(cyc), 128'd11);
    post_stream_checks("seq");

    // FIPS-197 key with a randomly stalling consumer
    push_sched(1'b1);
    load_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
    repeat (10) @(negedge clk);
    drain(11, 1'b1, cyc);
    post_stream_checks("fips");

    // Replay of the stored schedule
    replay = 1'b1;
`ifdef AES_DEC_KEY_ZEROIZE_EN
    @(negedge clk);
    replay = 1'b0;
    check("zrep_busy", {127'd0, busy}, 128'd0);
    expect_quiet("zrep_no_valid", 12);
    check("zrep_busy_end", {127'd0, busy}, 128'd0);
`else
    push_sched(1'b1);
    @(negedge clk);
    replay = 1'b0;
    check("rep_latency_valid", {127'd0, rk_valid}, 128'd1);
    drain(11, 1'b0, cyc);
    check("rep_cycles", 128'(cyc), 128'd11);
    post_stream_checks("rep");
`endif

    // Flush during expansion: abort and no replayable schedule
    load_key(128'h000102030405060708090a0b0c0d0e0f);
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_valid", {127'd0, rk_valid}, 128'd0);
`ifdef AES_DEC_KEY_ZEROIZE_EN
    check("flush_zero_busy", {127'd0, busy}, 128'd1);
    @(negedge clk);
`endif
    check("flush_busy", {127'd0, busy}, 128'd0);
    check("flush_key_ready", {127'd0, key_ready}, 128'd1);
    replay = 1'b1;
    @(negedge clk);
    replay = 1'b0;
    check("flush_replay_busy", {127'd0, busy}, 128'd0);
    expect_quiet("flush_replay_quiet", 14);

    // Flush beats a simultaneous key load in IDLE
    key_in    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    key_valid = 1'b1;
    flush     = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    flush     = 1'b0;
`ifdef AES_DEC_KEY_ZEROIZE_EN
    @(negedge clk);
`endif
    check("flushkey_busy", {127'd0, busy}, 128'd0);
    check("flushkey_key_ready", {127'd0, key_ready}, 128'd1);
    expect_quiet("flushkey_quiet", 14);

    // Asynchronous reset in the middle of a stream
    push_sched(1'b1);
    load_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
    repeat (10) @(negedge clk);
    drain(3, 1'b0, cyc);
    sb_q.delete();
    #2 rst_n = 1'b0;
    #1;
    check("arst_rk_out", rk_out, 128'd0);
    check("arst_rk_round", {124'd0, rk_round}, 128'd0);
    check("arst_rk_valid", {127'd0, rk_valid}, 128'd0);
    check("arst_rk_last", {127'd0, rk_last}, 128'd0);
    check("arst_busy", {127'd0, busy}, 128'd0);
    check("arst_key_ready", {127'd0, key_ready}, 128'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    replay = 1'b1;
    @(negedge clk);
    replay = 1'b0;
    expect_quiet("arst_replay_quiet", 13);

    // Normal operation after reset
    push_sched(1'b0);
    load_key(128'h000102030405060708090a0b0c0d0e0f);
    repeat (10) @(negedge clk);
    drain(11, 1'b1, cyc);
    post_stream_checks("after_rst");
    check("sb_empty", 128'(sb_q.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
